// File: rtl/uart_echo_buf.sv
// Buffered echo engine between uart_rx and uart_tx: a DEPTH-entry FIFO absorbs
// bursts, and each word is transformed by a mode-selected function on its way out.
module uart_echo_buf #(
  parameter int DW     = 8,
  parameter int DEPTH  = 16,
  parameter int OFFSET = 1,
  parameter int LED_W  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rcv,
  input  logic [DW-1:0]            rx_data,
  input  logic                     tx_ready,
  input  logic [1:0]               mode,
  input  logic                     clr_ovf,
  output logic                     tx_start,
  output logic [DW-1:0]            tx_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [LED_W-1:0]         leds
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_e;

  state_e            state_q;
  logic [DW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [DW-1:0]     tx_data_q;
  logic              tx_start_q;
  logic              overflow_q;
  logic [LED_W-1:0]  leds_q;

  logic empty;
  logic full;
  logic pop;
  logic push;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign pop   = (state_q == IDLE) && !empty && tx_ready;
  assign push  = rcv && (!full || pop);

  function automatic logic [DW-1:0] xform(input logic [DW-1:0] d, input logic [1:0] m);
    logic [DW-1:0] r;
    logic          is_alpha;
    r        = d;
    is_alpha = ((d >= DW'(8'h41)) && (d <= DW'(8'h5A))) ||
               ((d >= DW'(8'h61)) && (d <= DW'(8'h7A)));
    case (m)
      2'd1:    r = d - DW'(OFFSET);
      2'd2:    r = d + DW'(OFFSET);
      2'd3:    if (DW == 8 && is_alpha) r = d ^ DW'(8'h20);
      default: r = d;
    endcase
    return r;
  endfunction

  // NOTE: the storage array has no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      leds_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (rcv && full && !pop) overflow_q <= 1'b1;
      else if (clr_ovf)        overflow_q <= 1'b0;
      if (rcv) leds_q <= rx_data[LED_W-1:0];
    end
  end

  // Transmit handshake: pop and transform in IDLE, then track uart_tx busy/idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= xform(mem_q[rd_ptr_q], mode);
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            tx_start_q <= 1'b1;
            state_q    <= START;
          end
        end
        START:   state_q <= WAIT_LO;
        WAIT_LO: if (!tx_ready) state_q <= WAIT_HI;
        WAIT_HI: if (tx_ready)  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign leds     = leds_q;

endmodule

// File: tb/tb_uart_echo_buf.sv
// Scoreboard bench for uart_echo_buf: directed corner cases plus randomized bursts,
// with a uart_tx emulator driving tx_ready and a monitor checking every tx_start.
module tb_uart_echo_buf;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int OFFSET = 1;
  localparam int LED_W  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              rcv = 1'b0;
  logic [DW-1:0]     rx_data = '0;
  logic              tx_ready;
  logic [1:0]        mode = 2'd0;
  logic              clr_ovf = 1'b0;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [LED_W-1:0]  leds;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  started  = 0;
  bit  emu_en   = 1'b0;
  bit  ready_cmd = 1'b1;
  logic [DW-1:0] exp_q[$];

  uart_echo_buf #(.DW(DW), .DEPTH(DEPTH), .OFFSET(OFFSET), .LED_W(LED_W)) dut (
    .clk(clk), .rstn(rstn), .rcv(rcv), .rx_data(rx_data), .tx_ready(tx_ready),
    .mode(mode), .clr_ovf(clr_ovf), .tx_start(tx_start), .tx_data(tx_data),
    .level(level), .overflow(overflow), .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference transform from the mode table, in plain integer arithmetic.
  function automatic logic [DW-1:0] ref_f(input int d, input int m);
    int r;
    int modulus;
    modulus = 1 << DW;
    case (m)
      1:       r = ((d - OFFSET) % modulus + modulus) % modulus;
      2:       r = (d + OFFSET) % modulus;
      3:       r = ((d >= 65 && d <= 90) || (d >= 97 && d <= 122)) ? (d ^ 32) : d;
      default: r = d;
    endcase
    return r[DW-1:0];
  endfunction

  // uart_tx emulator: drops ready right after a start, stays busy a random frame time.
  initial begin
    int busy;
    busy = 0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!emu_en) begin
        tx_ready = ready_cmd;
        busy = 0;
      end else if (tx_start) begin
        tx_ready = 1'b0;
        busy = $urandom_range(2, 8);
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) tx_ready = 1'b1;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Monitor: every start pulse must present the oldest outstanding expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && tx_start) begin
        started++;
        if (exp_q.size() > 0) check("tx_data", tx_data, exp_q.pop_front());
        else check("tx_unexpected_outstanding", exp_q.size(), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit accepted);
    rcv = 1'b1;
    rx_data = d;
    if (accepted) exp_q.push_back(ref_f(int'(d), int'(mode)));
    tick();
    rcv = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && tx_ready && !tx_start) break;
    end
    check("drain_outstanding", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    tick();
  endtask

  // Called at posedge+1 with FIFO empty, FSM idle and tx_ready high.
  task automatic echo_latency(input logic [DW-1:0] d);
    logic [DW-1:0] e;
    e = ref_f(int'(d), int'(mode));
    rcv = 1'b1;
    rx_data = d;
    exp_q.push_back(e);
    @(negedge clk);
    check("lat_n_start", tx_start, 0);
    check("lat_n_level", level, 0);
    @(posedge clk);
    #1 rcv = 1'b0;
    @(negedge clk);
    check("lat_n1_start", tx_start, 0);
    check("lat_n1_level", level, 1);
    @(negedge clk);
    check("lat_n2_start", tx_start, 1);
    check("lat_n2_level", level, 0);
    check("lat_n2_data", tx_data, e);
    @(negedge clk);
    check("lat_n3_start", tx_start, 0);
  endtask

  initial begin
    int s0;
    logic [DW-1:0] vec[4];

    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_leds", leds, 0);
    repeat (3) tick();
    rstn = 1'b1;
    emu_en = 1'b1;
    repeat (3) tick();

    // Latency and mid-frame mode change.
    mode = 2'd0;
    echo_latency(8'h41);
    mode = 2'd2;
    wait_idle();
    check("tx_data_held", tx_data, 8'h41);

    // Wrapping arithmetic modes.
    mode = 2'd1;
    tick();
    send(8'h00, 1'b1);
    wait_idle();
    check("mode1_wrap", tx_data, 8'hFF);
    mode = 2'd2;
    tick();
    send(8'hFF, 1'b1);
    wait_idle();
    check("mode2_wrap", tx_data, 8'h00);

    // Case toggle, back-to-back burst.
    mode = 2'd3;
    tick();
    vec[0] = 8'h61; vec[1] = 8'h5A; vec[2] = 8'h40; vec[3] = 8'h5B;
    for (int i = 0; i < 4; i++) send(vec[i], 1'b1);
    wait_idle();

    // Overflow: 20 words while uart_tx is busy.
    mode = 2'd0;
    check("ovf_initial", overflow, 0);
    emu_en = 1'b0;
    ready_cmd = 1'b0;
    for (int i = 0; i < 20; i++) send(DW'(i), i < DEPTH);
    @(negedge clk);
    check("ovf_level_full", level, DEPTH);
    check("ovf_flag", overflow, 1);
    check("ovf_leds", leds, 8'h13 & ((1 << LED_W) - 1));
    tick();
    s0 = started;
    emu_en = 1'b1;
    wait_idle();
    check("ovf_sent_count", started - s0, DEPTH);
    check("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    @(negedge clk);
    check("ovf_cleared", overflow, 0);
    tick();

    // Push into a full FIFO in the same cycle as the pop.
    emu_en = 1'b0;
    ready_cmd = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(DW'($urandom_range(0, 255)), 1'b1);
    @(negedge clk);
    check("full_level", level, DEPTH);
    tick();
    ready_cmd = 1'b1;
    s0 = started;
    send(8'hA5, 1'b1);
    emu_en = 1'b1;
    @(negedge clk);
    check("pushpop_level", level, DEPTH);
    check("pushpop_overflow", overflow, 0);
    wait_idle();
    check("pushpop_sent_count", started - s0, DEPTH + 1);

    // Randomized bursts, one mode per batch, throttled below full.
    for (int b = 0; b < 4; b++) begin
      mode = 2'($urandom_range(0, 3));
      tick();
      for (int i = 0; i < 40; i++) begin
        for (int k = 0; k < 500 && exp_q.size() >= DEPTH - 2; k++) tick();
        send(DW'($urandom_range(0, 255)), 1'b1);
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle();
    end
    check("rand_no_overflow", overflow, 0);

    // Reset while waiting for uart_tx to go busy.
    mode = 2'd0;
    emu_en = 1'b0;
    ready_cmd = 1'b1;
    tick();
    send(8'h31, 1'b1);
    send(8'h32, 1'b1);
    send(8'h37, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_start) break;
    end
    check("rst_pre_start_seen", exp_q.size(), 2);
    tick();
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_tx_start", tx_start, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_level", level, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_leds", leds, 0);
    repeat (2) tick();
    rstn = 1'b1;
    s0 = started;
    repeat (10) tick();
    check("no_start_after_rst", started - s0, 0);
    emu_en = 1'b1;
    tick();
    echo_latency(8'h5A);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
